dot_stream_gen: RTL and testbench

- Producer side of the per-row dot-counting interface. Reads a stored image raster-order from a synchronous ROM/SRAM and drives the dot counter.
- Outputs: pixel-valid strobe (feeds the counter's enable), pixel data, and a one-cycle row-end strobe (feeds the counter's rowend clear).
- Sits between the image memory and the dot/window counting logic. Guarantees rowend never coincides with pixel-valid, so the consumer's rowend-over-enable priority never drops a pixel.

---
 rtl/dot_stream_gen_pkg.sv | 26 ++
 rtl/dot_stream_gen_raster_addr_cnt.sv | 66 ++++++
 rtl/dot_stream_gen.sv | 125 ++++++++++++
 tb/tb_dot_stream_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dot_stream_gen_pkg.sv
// Shared definitions for the dot streaming producer and the dot counter.
// Contents:
//   state_t    - producer FSM encoding (3-bit, IDLE=0 .. DONE=4)
//   DEF_*      - default image geometry / pixel width
//   cnt_w()    - counter width helper that never returns zero
package dot_stream_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_GAP    = 3'd2,
        ST_ROWEND = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam int DEF_IMG_W  = 8;
    localparam int DEF_IMG_H  = 8;
    localparam int DEF_PIX_W  = 8;
    localparam int DEF_ADDR_W = 6;

    // A 1-entry dimension still needs a 1-bit counter.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dot_stream_gen_raster_addr_cnt.sv
// Raster counters: column, row and linear memory address.
// Ports:
//   clk, rst   - clock, async active-low reset
//   frame_clr  - zero all counters (start of frame)
//   col_clr    - zero column counter (end of row)
//   adv        - one pixel issued: step column and address
//   row_adv    - step row counter
//   addr       - linear address row*IMG_W+col
//   last_col   - column counter at IMG_W-1
//   last_row   - row counter at IMG_H-1
// All counters saturate at their terminal values; the address never wraps.
module raster_addr_cnt
    import dot_stream_gen_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_clr,
    input  logic              col_clr,
    input  logic              adv,
    input  logic              row_adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_row
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    assign last_col = (col == COL_MAX);
    assign last_row = (row == ROW_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else if (frame_clr) begin
            col  <= '0;
            row  <= '0;
            addr <= '0;
        end else begin
            if (col_clr)
                col <= '0;
            else if (adv && !last_col)
                col <= col + 1'b1;

            if (row_adv && !last_row)
                row <= row + 1'b1;

            // Address runs across row boundaries, stopping only on the
            // final pixel of the frame.
            if (adv && !(last_col && last_row))
                addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/dot_stream_gen.sv
// Raster-order image reader feeding the per-row dot counter.
// Ports:
//   clk, rst    - clock, async active-low reset
//   start       - frame scan request, honoured only when idle
//   stall       - consumer back-pressure, blocks new memory reads
//   mem_rd      - memory read strobe
//   mem_addr    - memory read address (row*IMG_W+col)
//   mem_data    - memory read data, valid the cycle after mem_rd
//   pix_valid   - pixel strobe (counter enable)
//   pix_data    - pixel value, qualified by pix_valid
//   rowend      - one-cycle pulse after the last pixel of a row
//   busy        - frame in progress
//   done        - one-cycle frame-complete pulse
// A GAP cycle after each row's last read lets that pixel drain before
// ROWEND, so rowend never coincides with pix_valid.
module dot_stream_gen
    import dot_stream_gen_pkg::*;
#(
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [PIX_W-1:0]  mem_data,
    output logic              pix_valid,
    output logic [PIX_W-1:0]  pix_data,
    output logic              rowend,
    output logic              busy,
    output logic              done
);

    state_t state, state_nxt;

    logic             issue;
    logic             frame_clr, col_clr, row_adv;
    logic             last_col, last_row;
    logic [PIX_W-1:0] pix_hold;

    raster_addr_cnt #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .ADDR_W (ADDR_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .frame_clr (frame_clr),
        .col_clr   (col_clr),
        .adv       (issue),
        .row_adv   (row_adv),
        .addr      (mem_addr),
        .last_col  (last_col),
        .last_row  (last_row)
    );

    assign issue = (state == ST_FETCH) && !stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        frame_clr = 1'b0;
        col_clr   = 1'b0;
        row_adv   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    frame_clr = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (issue && last_col)
                    state_nxt = ST_GAP;
            end
            ST_GAP:
                state_nxt = ST_ROWEND;
            ST_ROWEND: begin
                col_clr = 1'b1;
                if (last_row) begin
                    state_nxt = ST_DONE;
                end else begin
                    row_adv   = 1'b1;
                    state_nxt = ST_FETCH;
                end
            end
            ST_DONE:
                state_nxt = ST_IDLE;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    assign mem_rd = issue;
    assign rowend = (state == ST_ROWEND);
    assign done   = (state == ST_DONE);
    assign busy   = (state == ST_FETCH) || (state == ST_GAP) || (state == ST_ROWEND);

    // Return path: one read in flight, data arrives with the registered strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_valid <= 1'b0;
            pix_hold  <= '0;
        end else begin
            pix_valid <= issue;
            if (pix_valid)
                pix_hold <= mem_data;
        end
    end

    // Memory data is passed straight through while valid; otherwise the last
    // pixel is held so the output stays frozen under stall.
    assign pix_data = pix_valid ? mem_data : pix_hold;

endmodule

// File: tb/tb_dot_stream_gen.sv
module tb_dot_stream_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b0;
    logic stall = 1'b0;
    logic start_a = 1'b0, start_b = 1'b0;

    // DUT A: 4x2 frame, ROM[i] = i
    logic       mem_rd_a, pix_valid_a, rowend_a, busy_a, done_a;
    logic [2:0] mem_addr_a;
    logic [7:0] mem_data_a = '0;
    logic [7:0] pix_data_a;

    // DUT B: 8x8 frame, ROM[i] = i*7+3
    logic       mem_rd_b, pix_valid_b, rowend_b, busy_b, done_b;
    logic [5:0] mem_addr_b;
    logic [7:0] mem_data_b = '0;
    logic [7:0] pix_data_b;

    dot_stream_gen #(.IMG_W(4), .IMG_H(2), .PIX_W(8), .ADDR_W(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .stall(stall),
        .mem_rd(mem_rd_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
        .pix_valid(pix_valid_a), .pix_data(pix_data_a), .rowend(rowend_a),
        .busy(busy_a), .done(done_a)
    );

    dot_stream_gen #(.IMG_W(8), .IMG_H(8), .PIX_W(8), .ADDR_W(6)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .stall(stall),
        .mem_rd(mem_rd_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .pix_valid(pix_valid_b), .pix_data(pix_data_b), .rowend(rowend_b),
        .busy(busy_b), .done(done_b)
    );

    function automatic logic [7:0] rom_b(input int a);
        return 8'((a * 7 + 3) % 256);
    endfunction

    always @(posedge clk) if (mem_rd_a) mem_data_a <= {5'd0, mem_addr_a};
    always @(posedge clk) if (mem_rd_b) mem_data_b <= rom_b(int'(mem_addr_b));

    int vecs = 0;
    int errs = 0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        vecs++;
        if ({mem_rd_a, pix_valid_a, rowend_a, busy_a, done_a} !== 5'b0) begin
            errs++;
            $display("FAIL reset_ctl_a got %b want 00000", {mem_rd_a, pix_valid_a, rowend_a, busy_a, done_a});
        end
        vecs++;
        if ({mem_addr_a, pix_data_a} !== 11'd0) begin
            errs++;
            $display("FAIL reset_data_a addr=%0d pix=%0d want 0/0", mem_addr_a, pix_data_a);
        end
        vecs++;
        if ({mem_rd_b, pix_valid_b, rowend_b, busy_b, done_b, mem_addr_b, pix_data_b} !== 19'd0) begin
            errs++;
            $display("FAIL reset_b got %b want all zero", {mem_rd_b, pix_valid_b, rowend_b, busy_b, done_b, mem_addr_b, pix_data_b});
        end
        #3 rst = 1'b1;
        tick();
        vecs++;
        if (busy_a !== 1'b0) begin
            errs++;
            $display("FAIL reset_release_busy got %b want 0", busy_a);
        end
    endtask

    task automatic test_basic;
        logic e_pv, e_re, e_dn, e_bz, e_rd;
        logic [7:0] exp;
        for (int i = 0; i < 8; i++) q_a.push_back(8'(i));
        for (int c = 0; c < 16; c++) begin
            start_a = (c == 0);
            e_pv = (c >= 2 && c <= 5) || (c >= 8 && c <= 11);
            e_re = (c == 6) || (c == 12);
            e_dn = (c == 13);
            e_bz = (c >= 1 && c <= 12);
            e_rd = (c >= 1 && c <= 4) || (c >= 7 && c <= 10);
            vecs++;
            if ({pix_valid_a, rowend_a, done_a, busy_a, mem_rd_a} !== {e_pv, e_re, e_dn, e_bz, e_rd}) begin
                errs++;
                $display("FAIL basic_ctl cycle %0d pv/re/dn/bz/rd got %b want %b", c,
                         {pix_valid_a, rowend_a, done_a, busy_a, mem_rd_a}, {e_pv, e_re, e_dn, e_bz, e_rd});
            end
            if (e_rd) begin
                vecs++;
                if (mem_addr_a !== 3'((c <= 4) ? c - 1 : c - 3)) begin
                    errs++;
                    $display("FAIL basic_addr cycle %0d got %0d want %0d", c, mem_addr_a, (c <= 4) ? c - 1 : c - 3);
                end
            end
            if (pix_valid_a) begin
                vecs++;
                if (q_a.size() == 0) begin
                    errs++;
                    $display("FAIL basic_extra_pixel cycle %0d got %0d want none", c, pix_data_a);
                end else begin
                    exp = q_a.pop_front();
                    if (pix_data_a !== exp) begin
                        errs++;
                        $display("FAIL basic_data cycle %0d got %0d want %0d", c, pix_data_a, exp);
                    end
                end
            end
            tick();
        end
        start_a = 1'b0;
        vecs++;
        if (q_a.size() != 0) begin
            errs++;
            $display("FAIL basic_missing got %0d left want 0", q_a.size());
        end
        q_a.delete();
    endtask

    task automatic test_stall;
        logic e_pv, e_re, e_dn, e_bz, e_rd;
        logic [7:0] exp;
        logic [2:0] ea;
        ea = 3'd0;
        for (int i = 0; i < 8; i++) q_a.push_back(8'(i));
        for (int c = 0; c < 19; c++) begin
            start_a = (c == 0);
            stall   = (c >= 2 && c <= 4);
            #1;
            e_rd = (c == 1) || (c >= 5 && c <= 7) || (c >= 10 && c <= 13);
            e_pv = (c == 2) || (c >= 6 && c <= 8) || (c >= 11 && c <= 14);
            e_re = (c == 9) || (c == 15);
            e_dn = (c == 16);
            e_bz = (c >= 1 && c <= 15);
            vecs++;
            if ({pix_valid_a, rowend_a, done_a, busy_a, mem_rd_a} !== {e_pv, e_re, e_dn, e_bz, e_rd}) begin
                errs++;
                $display("FAIL stall_ctl cycle %0d pv/re/dn/bz/rd got %b want %b", c,
                         {pix_valid_a, rowend_a, done_a, busy_a, mem_rd_a}, {e_pv, e_re, e_dn, e_bz, e_rd});
            end
            if (e_rd) begin
                vecs++;
                if (mem_addr_a !== ea) begin
                    errs++;
                    $display("FAIL stall_addr cycle %0d got %0d want %0d", c, mem_addr_a, ea);
                end
                ea = ea + 3'd1;
            end
            if (pix_valid_a) begin
                vecs++;
                if (q_a.size() == 0) begin
                    errs++;
                    $display("FAIL stall_extra_pixel cycle %0d got %0d want none", c, pix_data_a);
                end else begin
                    exp = q_a.pop_front();
                    if (pix_data_a !== exp) begin
                        errs++;
                        $display("FAIL stall_data cycle %0d got %0d want %0d", c, pix_data_a, exp);
                    end
                end
            end
            tick();
        end
        start_a = 1'b0;
        stall   = 1'b0;
        vecs++;
        if (q_a.size() != 0) begin
            errs++;
            $display("FAIL stall_missing got %0d left want 0", q_a.size());
        end
        q_a.delete();
    endtask

    task automatic test_reset_mid;
        for (int c = 0; c < 4; c++) begin
            start_a = (c == 0);
            tick();
        end
        start_a = 1'b0;
        // cycle 4: a read and a pixel are both live
        #2 rst = 1'b0;
        #1;
        vecs++;
        if ({mem_rd_a, pix_valid_a, rowend_a, busy_a, done_a, mem_addr_a, pix_data_a} !== 16'd0) begin
            errs++;
            $display("FAIL reset_mid_async got %b want all zero",
                     {mem_rd_a, pix_valid_a, rowend_a, busy_a, done_a, mem_addr_a, pix_data_a});
        end
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            vecs++;
            if ({done_a, busy_a, mem_rd_a, pix_valid_a} !== 4'b0) begin
                errs++;
                $display("FAIL reset_mid_idle cycle %0d dn/bz/rd/pv got %b want 0000", c,
                         {done_a, busy_a, mem_rd_a, pix_valid_a});
            end
        end
    endtask

    task automatic test_restart;
        logic e_re, e_dn, e_bz, e_rd;
        logic [7:0] exp;
        int f;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 8; i++) q_a.push_back(8'(i));
        for (int c = 0; c < 31; c++) begin
            // starts at 5 and 9 land mid-frame; 15 begins a fresh frame
            start_a = (c == 0) || (c == 5) || (c == 9) || (c == 15);
            f = (c >= 15) ? c - 15 : c;
            e_re = (c != 14) && (f == 6 || f == 12);
            e_dn = (c != 14) && (f == 13);
            e_bz = (c != 14) && (f >= 1 && f <= 12);
            e_rd = (c != 14) && ((f >= 1 && f <= 4) || (f >= 7 && f <= 10));
            vecs++;
            if ({rowend_a, done_a, busy_a, mem_rd_a} !== {e_re, e_dn, e_bz, e_rd}) begin
                errs++;
                $display("FAIL restart_ctl cycle %0d re/dn/bz/rd got %b want %b", c,
                         {rowend_a, done_a, busy_a, mem_rd_a}, {e_re, e_dn, e_bz, e_rd});
            end
            if (e_rd) begin
                vecs++;
                if (mem_addr_a !== 3'((f <= 4) ? f - 1 : f - 3)) begin
                    errs++;
                    $display("FAIL restart_addr cycle %0d got %0d want %0d", c, mem_addr_a, (f <= 4) ? f - 1 : f - 3);
                end
            end
            if (pix_valid_a) begin
                vecs++;
                if (q_a.size() == 0) begin
                    errs++;
                    $display("FAIL restart_extra_pixel cycle %0d got %0d want none", c, pix_data_a);
                end else begin
                    exp = q_a.pop_front();
                    if (pix_data_a !== exp) begin
                        errs++;
                        $display("FAIL restart_data cycle %0d got %0d want %0d", c, pix_data_a, exp);
                    end
                end
            end
            tick();
        end
        start_a = 1'b0;
        vecs++;
        if (q_a.size() != 0) begin
            errs++;
            $display("FAIL restart_missing got %0d left want 0", q_a.size());
        end
        q_a.delete();
    endtask

    task automatic test_overlap;
        int n_pv, n_re, n_dn, en_cnt, post;
        logic [7:0] exp;
        n_pv = 0; n_re = 0; n_dn = 0; en_cnt = 0; post = 0;
        for (int i = 0; i < 64; i++) q_b.push_back(rom_b(i));
        for (int c = 0; c < 3000; c++) begin
            start_b = (c == 0);
            vecs++;
            if (pix_valid_b && rowend_b) begin
                errs++;
                $display("FAIL overlap cycle %0d pix_valid and rowend both 1 want exclusive", c);
            end
            if (pix_valid_b) begin
                n_pv++;
                en_cnt++;
                vecs++;
                if (q_b.size() == 0) begin
                    errs++;
                    $display("FAIL overlap_extra_pixel cycle %0d got %0d want none", c, pix_data_b);
                end else begin
                    exp = q_b.pop_front();
                    if (pix_data_b !== exp) begin
                        errs++;
                        $display("FAIL overlap_data cycle %0d got %0d want %0d", c, pix_data_b, exp);
                    end
                end
            end
            if (rowend_b) begin
                n_re++;
                vecs++;
                if (en_cnt != 8) begin
                    errs++;
                    $display("FAIL row_enables row %0d got %0d want 8", n_re, en_cnt);
                end
                en_cnt = 0;
            end
            if (done_b) n_dn++;
            if (n_dn > 0) begin
                post++;
                if (post > 4) break;
            end
            stall = ($urandom_range(0, 3) == 0);
            tick();
        end
        start_b = 1'b0;
        stall   = 1'b0;
        vecs++;
        if (n_re != 8) begin
            errs++;
            $display("FAIL overlap_rowends got %0d want 8", n_re);
        end
        vecs++;
        if (n_pv != 64) begin
            errs++;
            $display("FAIL overlap_pixels got %0d want 64", n_pv);
        end
        vecs++;
        if (n_dn != 1) begin
            errs++;
            $display("FAIL overlap_done got %0d want 1", n_dn);
        end
        vecs++;
        if (busy_b !== 1'b0) begin
            errs++;
            $display("FAIL overlap_busy_end got %b want 0", busy_b);
        end
        q_b.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
        test_restart();
        test_overlap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
